// File: rtl/isa_io_target.sv
// isa_io_target: ISA I/O-space loopback target with a 4-port window.
// The window holds a byte FIFO, a status/control port, a scratch register and an IRQ threshold.
// Strobes, address and data are synchronised into the bus clock domain before they are decoded.
module isa_io_target #(
    parameter logic [15:0] BASE_ADDR  = 16'h0220,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] A,
    input  logic [15:0] D_in,
    output logic [15:0] D_out,
    output logic        D_oe,
    input  logic        IOR,
    input  logic        IOW,
    input  logic        AEN,
    output logic        IRQ
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = 5;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } state_t;

    // Synchroniser stages (_m first, _s second), previous second-stage strobe (_p)
    logic        ior_m, ior_s, ior_p;
    logic        iow_m, iow_s, iow_p;
    logic        aen_m, aen_s;
    logic [15:0] a_m, a_s;
    logic [7:0]  d_m, d_s;
    // Marks which pipeline stages hold real pin samples since the last reset
    logic [2:0]  smp_vld;

    logic        edge_vld;
    logic        ior_fall, ior_rise, iow_fall, iow_rise;
    logic        hit, go_rd, go_wr;

    state_t      state_q, state_d;
    logic        rd_end, wr_end;

    logic [1:0]       off_q;
    logic [7:0]       rd_data_q;
    logic [7:0]       rd_mux;
    logic [7:0]       scratch_q;
    logic             irq_en_q;
    logic [4:0]       thr_q;
    logic             ovf_q, unf_q;
    logic [CNT_W-1:0] count_q;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [7:0]       mem [FIFO_DEPTH];
    logic             fifo_push;

    logic unused_d_hi;
    assign unused_d_hi = ^D_in[15:8];

    // Two-flop synchroniser for strobes, address and data, plus edge history
    always_ff @(posedge clk) begin
        if (reset) begin
            ior_m   <= 1'b1;
            ior_s   <= 1'b1;
            ior_p   <= 1'b1;
            iow_m   <= 1'b1;
            iow_s   <= 1'b1;
            iow_p   <= 1'b1;
            aen_m   <= 1'b0;
            aen_s   <= 1'b0;
            a_m     <= '0;
            a_s     <= '0;
            d_m     <= '0;
            d_s     <= '0;
            smp_vld <= '0;
        end else begin
            ior_m   <= IOR;
            ior_s   <= ior_m;
            ior_p   <= ior_s;
            iow_m   <= IOW;
            iow_s   <= iow_m;
            iow_p   <= iow_s;
            aen_m   <= AEN;
            aen_s   <= aen_m;
            a_m     <= A;
            a_s     <= a_m;
            d_m     <= D_in[7:0];
            d_s     <= d_m;
            smp_vld <= {smp_vld[1:0], 1'b1};
        end
    end

    // Edges count only once both compared samples came from the pins, so a
    // strobe held low across reset does not look like a fresh falling edge.
    assign edge_vld = smp_vld[2];
    assign ior_fall = edge_vld &&  ior_p && !ior_s;
    assign ior_rise = edge_vld && !ior_p &&  ior_s;
    assign iow_fall = edge_vld &&  iow_p && !iow_s;
    assign iow_rise = edge_vld && !iow_p &&  iow_s;

    assign hit   = (a_s[15:2] == BASE_ADDR[15:2]) && !aen_s;
    // A strobe only starts a cycle while the opposite strobe is idle (high)
    assign go_rd = ior_fall && hit && iow_s;
    assign go_wr = iow_fall && hit && ior_s;

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (go_rd) begin
                    state_d = RD;
                end else if (go_wr) begin
                    state_d = WR;
                end
            end
            RD:      if (ior_rise) state_d = IDLE;
            WR:      if (iow_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: D_oe drops in the same cycle the IOR rising edge is seen
    always_comb begin
        D_oe   = 1'b0;
        rd_end = 1'b0;
        wr_end = 1'b0;
        case (state_q)
            RD: begin
                D_oe   = !ior_rise;
                rd_end = ior_rise;
            end
            WR:      wr_end = iow_rise;
            default: ;
        endcase
    end

    // Read data selected by the offset at RD entry
    always_comb begin
        rd_mux = 8'h00;
        case (a_s[1:0])
            2'd0:    rd_mux = (count_q == '0) ? 8'h00 : mem[rd_ptr_q];
            2'd1:    rd_mux = {ovf_q, unf_q, (count_q == '0), count_q};
            2'd2:    rd_mux = scratch_q;
            default: rd_mux = {irq_en_q, 2'b00, thr_q};
        endcase
    end

    assign fifo_push = wr_end && (off_q == 2'd0) && (count_q < DEPTH_CNT);

    // FIFO storage; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (!reset && fifo_push) begin
            mem[wr_ptr_q] <= d_s;
        end
    end

    // Register file, FIFO pointers and flags, IRQ output
    always_ff @(posedge clk) begin
        if (reset) begin
            off_q     <= '0;
            rd_data_q <= '0;
            scratch_q <= '0;
            irq_en_q  <= 1'b0;
            thr_q     <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            IRQ       <= 1'b0;
        end else begin
            if (go_rd || go_wr) begin
                off_q <= a_s[1:0];
            end
            if (go_rd) begin
                rd_data_q <= rd_mux;
            end
            if (rd_end && (off_q == 2'd0)) begin
                if (count_q == '0) begin
                    unf_q <= 1'b1;
                end else begin
                    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                    count_q  <= count_q - CNT_W'(1);
                end
            end
            if (wr_end) begin
                case (off_q)
                    2'd0: begin
                        if (count_q < DEPTH_CNT) begin
                            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                            count_q  <= count_q + CNT_W'(1);
                        end else begin
                            ovf_q <= 1'b1;
                        end
                    end
                    2'd1: begin
                        if (d_s[7]) ovf_q <= 1'b0;
                        if (d_s[6]) unf_q <= 1'b0;
                        if (d_s[0]) begin
                            count_q  <= '0;
                            wr_ptr_q <= '0;
                            rd_ptr_q <= '0;
                        end
                    end
                    2'd2: scratch_q <= d_s;
                    default: begin
                        irq_en_q <= d_s[7];
                        thr_q    <= d_s[4:0];
                    end
                endcase
            end
            IRQ <= irq_en_q && (thr_q != '0) && (count_q >= thr_q);
        end
    end

    assign D_out = {8'h00, rd_data_q};

endmodule

// File: tb/tb_isa_io_target.sv
// tb_isa_io_target: scoreboard bench for isa_io_target; reads push expected data, a monitor checks D_out/D_oe.
module tb_isa_io_target;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] A;
    logic [15:0] D_in;
    logic [15:0] D_out;
    logic        D_oe;
    logic        IOR;
    logic        IOW;
    logic        AEN;
    logic        IRQ;

    isa_io_target #(
        .BASE_ADDR (16'h0220),
        .FIFO_DEPTH(16)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .A    (A),
        .D_in (D_in),
        .D_out(D_out),
        .D_oe (D_oe),
        .IOR  (IOR),
        .IOW  (IOW),
        .AEN  (AEN),
        .IRQ  (IRQ)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] data;
        int          width;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   checks = 0;
    int   passes = 0;
    int   oe_rises = 0;
    int   oe_width = 0;
    logic oe_prev = 1'b0;
    logic [15:0] oe_data;
    logic irq_commit;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got === want) passes++;
        else $display("FAIL %s: got 0x%04h expected 0x%04h", name, got, want);
    endtask

    // Monitor: pop an expectation on each D_oe pulse, check data, stability and width
    always @(negedge clk) begin
        if (D_oe && !oe_prev) begin
            oe_rises++;
            oe_width = 1;
            oe_data  = D_out;
            check("oe_expected", 16'(exp_q.size() != 0), 16'd1);
            if (exp_q.size() != 0) begin
                cur = exp_q.pop_front();
                check({cur.name, "_data"}, D_out, cur.data);
            end else begin
                cur.name  = "unexpected";
                cur.data  = 16'h0;
                cur.width = 0;
            end
        end else if (D_oe) begin
            oe_width++;
            if (D_out !== oe_data) check({cur.name, "_stable"}, D_out, oe_data);
        end else if (oe_prev) begin
            check({cur.name, "_oe_width"}, 16'(oe_width), 16'(cur.width));
        end
        oe_prev = D_oe;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ISA I/O write: strobe low 4 clocks, data held until the trailing edge is seen
    task automatic io_write(input logic [15:0] addr, input logic [7:0] data, input logic aen);
        A    = addr;
        D_in = {8'hEE, data};
        AEN  = aen;
        tick();
        IOW = 1'b0;
        repeat (4) tick();
        IOW = 1'b1;
        repeat (3) tick();
        irq_commit = IRQ;
        repeat (3) tick();
        AEN = 1'b0;
    endtask

    // ISA I/O read: strobe low 4 clocks gives a 3-clock D_oe pulse
    task automatic io_read(input string name, input logic [15:0] addr, input logic [15:0] want,
                           input logic expect_resp);
        exp_t e;
        if (expect_resp) begin
            e.name  = name;
            e.data  = want;
            e.width = 3;
            exp_q.push_back(e);
        end
        A   = addr;
        AEN = 1'b0;
        tick();
        IOR = 1'b0;
        repeat (4) tick();
        IOR = 1'b1;
        repeat (5) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rises_before;
        reset = 1'b1;
        A     = 16'h0000;
        D_in  = 16'h0000;
        IOR   = 1'b1;
        IOW   = 1'b1;
        AEN   = 1'b0;
        repeat (3) tick();
        check("reset_d_oe", 16'(D_oe), 16'h0);
        check("reset_d_out", D_out, 16'h0000);
        check("reset_irq", 16'(IRQ), 16'h0);
        reset = 1'b0;
        repeat (2) tick();

        // Scratch loopback
        io_write(16'h0222, 8'hA5, 1'b0);
        io_read("scratch", 16'h0222, 16'h00A5, 1'b1);

        // FIFO fill, overflow, drain in order
        for (int i = 1; i <= 16; i++) io_write(16'h0220, 8'(i), 1'b0);
        io_read("status_full", 16'h0221, 16'h0010, 1'b1);
        io_write(16'h0220, 8'hFF, 1'b0);
        io_read("status_ovf", 16'h0221, 16'h0090, 1'b1);
        for (int i = 1; i <= 16; i++) io_read("fifo_pop", 16'h0220, 16'(i), 1'b1);
        io_read("status_drained", 16'h0221, 16'h00A0, 1'b1);

        // Clear OVF, then underflow and clear UNF
        io_write(16'h0221, 8'h80, 1'b0);
        io_read("status_ovf_clr", 16'h0221, 16'h0020, 1'b1);
        io_read("fifo_empty", 16'h0220, 16'h0000, 1'b1);
        io_read("status_unf", 16'h0221, 16'h0060, 1'b1);
        io_write(16'h0221, 8'hC0, 1'b0);
        io_read("status_unf_clr", 16'h0221, 16'h0020, 1'b1);

        // IRQ threshold
        io_write(16'h0223, 8'h84, 1'b0);
        io_read("irq_ctrl", 16'h0223, 16'h0084, 1'b1);
        for (int i = 0; i < 3; i++) io_write(16'h0220, 8'(8'h11 + i), 1'b0);
        check("irq_below_thr", 16'(IRQ), 16'h0);
        io_write(16'h0220, 8'h14, 1'b0);
        check("irq_at_commit", 16'(irq_commit), 16'h0);
        check("irq_after_commit", 16'(IRQ), 16'h1);
        io_read("irq_pop", 16'h0220, 16'h0011, 1'b1);
        check("irq_after_pop", 16'(IRQ), 16'h0);

        // Decode guards
        rises_before = oe_rises;
        io_read("miss", 16'h0224, 16'h0000, 1'b0);
        check("miss_no_oe", 16'(oe_rises), 16'(rises_before));
        io_write(16'h0220, 8'h55, 1'b1);
        io_read("status_aen", 16'h0221, 16'h0003, 1'b1);
        rises_before = oe_rises;
        A = 16'h0220;
        tick();
        IOR = 1'b0;
        IOW = 1'b0;
        repeat (4) tick();
        IOR = 1'b1;
        IOW = 1'b1;
        repeat (5) tick();
        check("both_low_no_oe", 16'(oe_rises), 16'(rises_before));
        io_read("status_both", 16'h0221, 16'h0003, 1'b1);

        // Flush
        io_write(16'h0221, 8'h01, 1'b0);
        io_read("status_flush", 16'h0221, 16'h0020, 1'b1);

        // Reset while D_oe is high; a held-low IOR must not retrigger
        begin
            exp_t e;
            e.name  = "reset_read";
            e.data  = 16'h00A5;
            e.width = 1;
            exp_q.push_back(e);
        end
        io_write(16'h0220, 8'h77, 1'b0);
        A = 16'h0222;
        tick();
        IOR = 1'b0;
        repeat (3) tick();
        check("oe_before_reset", 16'(D_oe), 16'h1);
        reset = 1'b1;
        tick();
        check("oe_after_reset", 16'(D_oe), 16'h0);
        tick();
        reset = 1'b0;
        rises_before = oe_rises;
        repeat (6) tick();
        check("held_ior_no_retrigger", 16'(oe_rises), 16'(rises_before));
        IOR = 1'b1;
        repeat (4) tick();
        io_read("status_post_reset", 16'h0221, 16'h0020, 1'b1);
        io_read("scratch_post_reset", 16'h0222, 16'h0000, 1'b1);

        repeat (4) tick();
        check("queue_drained", 16'(exp_q.size()), 16'h0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/isa_io_target.md
Name: isa_io_target

Overview:
ISA I/O-space responder: the target end of the IOR/IOW cycles issued by the host-side bus interface. It decodes a 4-port window at BASE_ADDR and serves a byte FIFO data port, a status/control port, a scratch register and an IRQ-threshold register. It sits on the riser's bus side as a loopback/bring-up target, so the host state machine can be exercised without a sound card fitted. It runs on the bus clock domain; ISA strobes are asynchronous to it and are synchronised internally.

Parameters:
BASE_ADDR  16'h0220  I/O base; the window is BASE_ADDR..BASE_ADDR+3, decoded on A[15:2].
FIFO_DEPTH  16  data FIFO depth in bytes; power of 2, max 16; count is 5 bits.

Ports:
clk  in  1  bus clock (8 MHz).
reset  in  1  synchronous, active-high reset.
A  in  16  ISA address.
D_in  in  16  ISA data in; only D_in[7:0] is used.
D_out  out  16  read data; [15:8] is always 0.
D_oe  out  1  enables D_out onto the shared bus.
IOR  in  1  ISA I/O read strobe, active-low.
IOW  in  1  ISA I/O write strobe, active-low.
AEN  in  1  address enable; a high level means a DMA cycle, so decode is blocked.
IRQ  out  1  interrupt request, active-high level.

Behaviour:
- Synchronisation: IOR, IOW, AEN, A and D_in[7:0] pass through 2 flops together, so they stay aligned. Edges are detected on the second stage.
- hit = (A_s[15:2] == BASE_ADDR[15:2]) && !AEN_s. The offset is A_s[1:0].
- FSM states: IDLE, RD, WR.
- IDLE -> RD: on the IOR falling edge with hit.
  - The offset is latched and the read data is latched.
  - D_oe goes to 1 on the next cycle, so D_oe is valid 3 clk after the pin edge.
- RD -> IDLE: on the IOR rising edge.
  - D_oe goes to 0 in the same cycle the edge is detected.
  - Side effects (FIFO pop) happen in that cycle.
- IDLE -> WR: on the IOW falling edge with hit. The offset is latched.
- WR -> IDLE: on the IOW rising edge. The write commits using the D_s value sampled in that cycle (trailing-edge data).
- Strobe misuse:
  - IOR and IOW both low in IDLE: no transition.
  - The opposite strobe falling while in RD or WR is ignored.
  - A miss (no hit, or AEN high) never leaves IDLE and never drives D_oe.
- Offset 0, FIFO data port:
  - Write: pushes the byte if count < FIFO_DEPTH; otherwise the byte is dropped and OVF is set.
  - Read: returns the head byte. If empty it returns 8'h00 and sets UNF.
  - The pop happens at the end of the read and only when not empty.
  - The read data is latched at RD entry, so it stays stable while D_oe is high.
  - Pointers wrap modulo FIFO_DEPTH.
- Offset 1, status and control:
  - Read: {OVF, UNF, EMPTY, count[4:0]}.
  - Write: bit7=1 clears OVF and bit6=1 clears UNF (write-1-to-clear); bit0=1 flushes the FIFO (count=0, pointers=0).
  - A flush in the same cycle as a clear performs both.
- Offset 2, scratch: 8-bit read/write.
- Offset 3, IRQ control:
  - Fields: bit7 = IRQ_EN, bits[4:0] = THR; bits 6:5 read as 0.
  - IRQ = IRQ_EN && THR != 0 && count >= THR. It is registered, so it updates 1 clk after count or control changes.
- Reset values:
  - FSM = IDLE, D_oe = 0, D_out = 0, IRQ = 0.
  - Scratch = 0, IRQ control = 0, OVF = UNF = 0, count = 0, pointers = 0.
  - Synchroniser flops reset to 1 for IOR/IOW (idle), 0 otherwise.
- Reset mid-cycle: D_oe drops on the next edge. A write in flight is lost, and the FSM waits in IDLE for a fresh falling edge (a held-low strobe does not retrigger).

Test Plan:
- Scratch loopback: IOW 0x0222 <- 0xA5, then IOR 0x0222 -> D_out = 0x00A5. D_oe is high only between the detected IOR edges.
- FIFO order and full:
  - Write 0x01..0x10 to 0x0220 -> status = 0x10.
  - A 17th write of 0xFF -> status = 0x90 (OVF set).
  - 16 reads return 0x01..0x10 in order, then status = 0xA0.
- Underflow and clear:
  - Read 0x0220 while empty -> 0x00 with UNF set (status 0x60).
  - Write 0xC0 to 0x0221 -> status 0x20.
- IRQ threshold:
  - Write 0x84 to 0x0223, then push 3 bytes -> IRQ = 0.
  - The 4th push -> IRQ = 1 one clk after commit.
  - One pop -> IRQ = 0.
- Decode guards:
  - IOR at 0x0224 -> D_oe stays 0.
  - IOW at 0x0220 with AEN = 1 -> count unchanged.
  - IOR and IOW low together -> no response.
- Reset mid-read: assert reset while D_oe = 1 -> D_oe = 0 next clk and status reads 0x20 afterwards.
